exe_stage: RTL

//  Execute stage. Consumes the ID/EXE pipeline register outputs and produces ALU result, store data, branch target and NZCV for the EXE/MEM register and condition check.

---
 rtl/exe_stage_pkg.sv | 43 ++++
 rtl/exe_stage_val2_generator.sv | 44 ++++
 rtl/exe_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types,
// forwarding selects and the iterative multiplier state.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_REG2 = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Bit positions inside the 4-bit NZCV word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand: rotated 8-bit immediate, raw 12-bit memory offset,
// or the forwarded Rm through the barrel shifter.
module val2_generator
  import exe_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  imm,
  input  logic                  mem,
  input  logic [11:0]           shiftOperand,
  input  logic [DATA_WIDTH-1:0] opRm,
  output logic [DATA_WIDTH-1:0] val2
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0]   imm8;
  logic [4:0]     rot;
  logic [4:0]     amt;
  logic [2*W-1:0] imm_dbl;
  logic [2*W-1:0] rm_dbl;

  always_comb begin
    imm8    = {{(W-8){1'b0}}, shiftOperand[7:0]};
    rot     = {shiftOperand[11:8], 1'b0};
    amt     = shiftOperand[11:7];
    // Rotates come from the low half of a doubled word shifted right
    imm_dbl = {imm8, imm8} >> rot;
    rm_dbl  = {opRm, opRm} >> amt;
    if (imm)
      val2 = imm_dbl[W-1:0];
    else if (mem)
      val2 = {{(W-12){1'b0}}, shiftOperand};
    else begin
      case (shift_e'(shiftOperand[6:5]))
        SH_LSL:  val2 = opRm << amt;
        SH_LSR:  val2 = opRm >> amt;
        SH_ASR:  val2 = $signed(opRm) >>> amt;
        default: val2 = rm_dbl[W-1:0];
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, val2, ALU, NZCV register, branch target
// and an iterative shift-add multiplier that stalls the front end.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            exeCmd,
  input  logic [2:0]            ctrlIn,
  input  logic                  b,
  input  logic                  s,
  input  logic                  imm,
  input  logic                  isMul,
  input  logic [31:0]           pc,
  input  logic [DATA_WIDTH-1:0] valRn,
  input  logic [DATA_WIDTH-1:0] valRm,
  input  logic [11:0]           shiftOperand,
  input  logic [23:0]           signedImm24,
  input  logic [3:0]            fwdSel,
  input  logic [DATA_WIDTH-1:0] memFwdVal,
  input  logic [DATA_WIDTH-1:0] wbFwdVal,
  output logic [DATA_WIDTH-1:0] aluRes,
  output logic [DATA_WIDTH-1:0] storeVal,
  output logic [31:0]           branchAddr,
  output logic [3:0]            statusOut,
  output logic                  stall,
  output logic [2:0]            ctrlOut
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = DATA_WIDTH / MUL_BITS;
  localparam int CW = $clog2(N) + 1;

  // b is consumed by the EXE/MEM register directly, not here
  logic unused_b;
  assign unused_b = b;

  logic [W-1:0] op_rn, op_rm, val2;
  logic         mem_op;
  logic [3:0]   cmd_eff;
  logic [3:0]   status;

  always_comb begin
    case (fwd_e'(fwdSel[1:0]))
      FWD_MEM: op_rn = memFwdVal;
      FWD_WB:  op_rn = wbFwdVal;
      default: op_rn = valRn;
    endcase
    case (fwd_e'(fwdSel[3:2]))
      FWD_MEM: op_rm = memFwdVal;
      FWD_WB:  op_rm = wbFwdVal;
      default: op_rm = valRm;
    endcase
  end

  assign mem_op     = ctrlIn[1] | ctrlIn[0];
  assign cmd_eff    = mem_op ? CMD_ADD : exeCmd;
  assign storeVal   = op_rm;
  assign branchAddr = pc + {{6{signedImm24[23]}}, signedImm24, 2'b00};

  val2_generator #(.DATA_WIDTH(W)) u_val2 (
    .imm          (imm),
    .mem          (mem_op),
    .shiftOperand (shiftOperand),
    .opRm         (op_rm),
    .val2         (val2)
  );

  // ALU: subtraction is a + ~b + cin so C directly means "no borrow"
  logic [W-1:0] res, bb;
  logic [W:0]   sum;
  logic         arith, sub, cin, c_new, v_new;

  always_comb begin
    res   = '0;
    arith = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    case (cmd_eff)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = op_rn & val2;
      CMD_ORR: res = op_rn | val2;
      CMD_EOR: res = op_rn ^ val2;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = status[FLAG_C]; end
      CMD_SUB: begin arith = 1'b1; sub = 1'b1; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; sub = 1'b1; cin = status[FLAG_C]; end
      default: res = '0;
    endcase
    bb    = sub ? ~val2 : val2;
    sum   = {1'b0, op_rn} + {1'b0, bb} + {{W{1'b0}}, cin};
    c_new = status[FLAG_C];
    v_new = status[FLAG_V];
    if (arith) begin
      res   = sum[W-1:0];
      c_new = sum[W];
      v_new = (op_rn[W-1] == bb[W-1]) && (res[W-1] != op_rn[W-1]);
    end
  end

  // Multiplier
  mul_state_e    state;
  logic [W-1:0]  mcand, mplier, prod, digit, partial;
  logic [CW-1:0] cnt;
  logic [3:0]    nzcv_d;

  assign digit   = W'(mplier[MUL_BITS-1:0]);
  assign partial = mcand * digit;
  assign stall   = (state == MUL_BUSY) || (state == MUL_IDLE && isMul);
  assign ctrlOut = ctrlIn & {3{~stall}};

  always_comb begin
    if (state == MUL_DONE) begin
      aluRes = prod;
      nzcv_d = {prod[W-1], prod == '0, status[FLAG_C], status[FLAG_V]};
    end else begin
      aluRes = res;
      nzcv_d = {res[W-1], res == '0, c_new, v_new};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      status <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      if (s && !stall)
        status <= nzcv_d;
      case (state)
        MUL_IDLE: if (isMul) begin
          mcand  <= op_rn;
          mplier <= op_rm;
          prod   <= '0;
          cnt    <= '0;
          state  <= MUL_BUSY;
        end
        MUL_BUSY: begin
          prod   <= prod + partial;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1))
            state <= MUL_DONE;
        end
        // Always drop back to IDLE so the still-held isMul cannot retrigger
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign statusOut = status;

endmodule
